// File: rtl/demosaic_window_ctrl.sv
// demosaic_window_ctrl: raster sequencer for a 7x7 Bayer demosaic window.
// Accepts a pixel stream, inserts 3 pad columns per row and 3 pad rows per
// frame, and drives line-buffer write/rotation, window shift and centre tags.
//   clk, rst_n            : pixel clock, async active-low reset
//   pix_valid/ready/sof   : input pixel handshake, sof marks pixel (0,0)
//   out_ready             : global advance enable; no beat when low
//   lb_wr_en/addr, lb_rot : line-buffer write strobe, column, newest buffer
//   win_shift             : advance window one column (every beat)
//   pad_col, pad_row      : beat is a virtual column / virtual row
//   win_valid/row/col/phase : complete window centre and Bayer phase
//   frame_done, sof_err   : end-of-frame pulse, mid-frame sof pulse
module demosaic_window_ctrl #(
    parameter int         IMG_W     = 1920,
    parameter int         IMG_H     = 1080,
    parameter int         CW        = 12,
    parameter int         RW        = 12,
    parameter logic [1:0] BAYER_PAT = 2'b00
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic          pix_sof,
    input  logic          out_ready,
    output logic          lb_wr_en,
    output logic [CW-1:0] lb_wr_addr,
    output logic [2:0]    lb_rot,
    output logic          win_shift,
    output logic          pad_col,
    output logic          pad_row,
    output logic          win_valid,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic [1:0]    win_phase,
    output logic          frame_done,
    output logic          sof_err
);
    typedef enum logic [2:0] {S_IDLE, S_ROW, S_HPAD, S_VPAD, S_DONE} state_t;

    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] C_W    = CW'(IMG_W);
    localparam logic [CW-1:0] C_END  = CW'(IMG_W + 2);
    localparam logic [CW-1:0] C_3    = CW'(3);
    localparam logic [RW-1:0] R_H    = RW'(IMG_H);
    localparam logic [RW-1:0] R_HL   = RW'(IMG_H - 1);
    localparam logic [RW-1:0] R_END  = RW'(IMG_H + 2);
    localparam logic [RW-1:0] R_3    = RW'(3);

    state_t        r_state;
    logic [CW-1:0] r_scol;
    logic [RW-1:0] r_srow;

    logic          w_pix_beat, w_pad_beat, w_sof, w_err, w_real, w_beat;
    logic          w_row_end, w_win;
    logic [CW-1:0] w_col, w_wc;
    logic [RW-1:0] w_row, w_wr;

    assign pix_ready  = rst_n & out_ready & (r_state == S_IDLE || r_state == S_ROW);
    assign w_pix_beat = pix_valid & pix_ready;
    assign w_pad_beat = out_ready & (r_state == S_HPAD || r_state == S_VPAD);
    assign w_sof      = w_pix_beat & pix_sof;
    assign w_err      = w_sof & (r_state == S_ROW) & (r_scol != '0 || r_srow != '0);
    // pixels in IDLE without sof are consumed but never become beats
    assign w_real     = w_pix_beat & (r_state == S_ROW || pix_sof);
    assign w_beat     = w_real | w_pad_beat;
    // a sof beat is always position (0,0), wherever the counters were
    assign w_col      = w_sof ? '0 : r_scol;
    assign w_row      = w_sof ? '0 : r_srow;
    assign w_row_end  = w_pad_beat & (r_scol == C_END);
    assign w_win      = w_beat & (w_row >= R_3) & (w_col >= C_3);
    assign w_wc       = w_col - C_3;
    assign w_wr       = w_row - R_3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_scol     <= '0;
            r_srow     <= '0;
            lb_wr_en   <= 1'b0;
            lb_wr_addr <= '0;
            lb_rot     <= '0;
            win_shift  <= 1'b0;
            pad_col    <= 1'b0;
            pad_row    <= 1'b0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            win_phase  <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            lb_wr_en   <= w_real;
            win_shift  <= w_beat;
            win_valid  <= w_win;
            sof_err    <= w_err;
            frame_done <= (r_state == S_DONE);
            if (w_beat) begin
                lb_wr_addr <= w_col;
                pad_col    <= w_col >= C_W;
                pad_row    <= w_row >= R_H;
            end
            if (w_win) begin
                win_row   <= w_wr;
                win_col   <= w_wc;
                win_phase <= {w_wr[0] ^ BAYER_PAT[1], w_wc[0] ^ BAYER_PAT[0]};
            end
            if (w_sof) begin
                r_scol  <= CW'(1);
                r_srow  <= '0;
                r_state <= S_ROW;
            end else if (w_beat) begin
                r_scol <= w_row_end ? '0 : r_scol + 1'b1;
                if (w_row_end) begin
                    r_srow <= r_srow + 1'b1;
                    lb_rot <= (lb_rot == 3'd6) ? 3'd0 : lb_rot + 3'd1;
                end
                if (r_state == S_ROW && r_scol == C_LAST)
                    r_state <= S_HPAD;
                else if (w_row_end)
                    r_state <= (r_srow == R_END) ? S_DONE :
                               (r_srow < R_HL)   ? S_ROW  : S_VPAD;
            end else if (r_state == S_DONE) begin
                r_state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_demosaic_window_ctrl.sv
// tb_demosaic_window_ctrl: directed bench for the 7x7 window sequencer on an 8x6 frame.
module tb_demosaic_window_ctrl;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = 5;
    localparam int RW = 5;

    logic clk = 0, rst_n = 0, pix_valid = 0, pix_sof = 0, out_ready = 0;
    logic pix_ready, lb_wr_en, win_shift, pad_col, pad_row, win_valid, frame_done, sof_err;
    logic [CW-1:0] lb_wr_addr, win_col;
    logic [RW-1:0] win_row;
    logic [2:0] lb_rot;
    logic [1:0] win_phase;
    logic pix_ready_b, lb_wr_en_b, win_shift_b, pad_col_b, pad_row_b, win_valid_b, frame_done_b, sof_err_b;
    logic [CW-1:0] lb_wr_addr_b, win_col_b;
    logic [RW-1:0] win_row_b;
    logic [2:0] lb_rot_b;
    logic [1:0] win_phase_b;

    demosaic_window_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW), .BAYER_PAT(2'b00)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
        .out_ready(out_ready), .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr), .lb_rot(lb_rot),
        .win_shift(win_shift), .pad_col(pad_col), .pad_row(pad_row), .win_valid(win_valid),
        .win_row(win_row), .win_col(win_col), .win_phase(win_phase), .frame_done(frame_done),
        .sof_err(sof_err));

    demosaic_window_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW), .BAYER_PAT(2'b01)) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready_b), .pix_sof(pix_sof),
        .out_ready(out_ready), .lb_wr_en(lb_wr_en_b), .lb_wr_addr(lb_wr_addr_b), .lb_rot(lb_rot_b),
        .win_shift(win_shift_b), .pad_col(pad_col_b), .pad_row(pad_row_b), .win_valid(win_valid_b),
        .win_row(win_row_b), .win_col(win_col_b), .win_phase(win_phase_b), .frame_done(frame_done_b),
        .sof_err(sof_err_b));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int wv_cnt = 0, wr_cnt = 0, sh_cnt = 0, fd_cnt = 0, se_cnt = 0, pr_cnt = 0, er = 0, ec = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: windows must appear in raster order starting at (0,0).
    always @(negedge clk) begin
        if (rst_n) begin
            if (win_shift) sh_cnt++;
            if (win_shift && pad_row) pr_cnt++;
            if (lb_wr_en) wr_cnt++;
            if (frame_done) fd_cnt++;
            if (sof_err) se_cnt++;
            if (win_valid) begin
                chk("win_row", win_row, er);
                chk("win_col", win_col, ec);
                chk("phase_pat00", win_phase, (er % 2) * 2 + (ec % 2));
                chk("phase_pat01", win_phase_b, (er % 2) * 2 + 1 - (ec % 2));
                wv_cnt++;
                if (ec == W - 1) begin
                    ec = 0;
                    er++;
                end else ec++;
            end
        end
    end

    typedef struct {
        logic v, s, r;
        logic rdy, wr, sh, pc, err;
        int   addr;
    } vec_t;
    vec_t tbl[16];

    function automatic vec_t mk(input logic v, s, r, rdy, wr, sh, pc, err, input int addr);
        vec_t x;
        x.v = v; x.s = s; x.r = r; x.rdy = rdy; x.wr = wr; x.sh = sh; x.pc = pc; x.err = err; x.addr = addr;
        return x;
    endfunction

    task automatic run_frame(input bit toggle, input bit stall, input int sof_pix, input int abort,
                             input int e_wr, input int e_sh, input int e_se, input int e_rot);
        int n = 0, cyc = 0, npix;
        bit acc, stl;
        npix = (sof_pix >= 0) ? sof_pix + W * H : W * H;
        wv_cnt = 0; wr_cnt = 0; sh_cnt = 0; fd_cnt = 0; se_cnt = 0; pr_cnt = 0; er = 0; ec = 0;
        while (fd_cnt == 0 && cyc < 400 && cyc != abort) begin
            stl = stall && ((cyc >= 9 && cyc < 14) || (cyc >= 80 && cyc < 85));
            out_ready = !stl;
            pix_valid = (n < npix) && (!toggle || cyc % 2 == 0);
            pix_sof = (n == 0) || (n == sof_pix);
            @(negedge clk);
            if (stl) chk("stall_pix_ready", pix_ready, 0);
            acc = pix_valid & pix_ready;
            @(posedge clk); #1;
            if (acc) n++;
            if (stl) begin
                chk("stall_win_valid", win_valid, 0);
                chk("stall_win_shift", win_shift, 0);
            end
            cyc++;
        end
        pix_valid = 0; pix_sof = 0; out_ready = 1;
        if (abort < 0) begin
            repeat (3) @(posedge clk);
            #1;
            chk("frame_done_count", fd_cnt, 1);
            chk("win_valid_count", wv_cnt, W * H);
            chk("lb_wr_en_count", wr_cnt, e_wr);
            chk("win_shift_count", sh_cnt, e_sh);
            chk("pad_row_count", pr_cnt, 3 * (W + 3));
            chk("sof_err_count", se_cnt, e_se);
            chk("lb_rot", lb_rot, e_rot);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; pix_valid = 0; pix_sof = 0; out_ready = 1;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 1, 1, 1, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 4; i <= 10; i++) tbl[i] = mk(1, 0, 1, 1, 1, 1, 0, 0, i - 3);
        for (int i = 11; i <= 13; i++) tbl[i] = mk(1, 0, 1, 0, 0, 1, 1, 0, i - 3);
        tbl[14] = mk(1, 0, 1, 1, 1, 1, 0, 0, 0);
        tbl[15] = mk(1, 1, 1, 1, 1, 1, 0, 1, 0);

        out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_lb_wr_en", lb_wr_en, 0);
        chk("rst_win_shift", win_shift, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_lb_rot", lb_rot, 0);
        rst_n = 1;

        for (int i = 0; i < 16; i++) begin
            pix_valid = tbl[i].v; pix_sof = tbl[i].s; out_ready = tbl[i].r;
            @(negedge clk);
            chk($sformatf("vec%0d_pix_ready", i), pix_ready, tbl[i].rdy);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_lb_wr_en", i), lb_wr_en, tbl[i].wr);
            chk($sformatf("vec%0d_win_shift", i), win_shift, tbl[i].sh);
            chk($sformatf("vec%0d_sof_err", i), sof_err, tbl[i].err);
            chk($sformatf("vec%0d_win_valid", i), win_valid, 0);
            if (tbl[i].sh) begin
                chk($sformatf("vec%0d_lb_wr_addr", i), lb_wr_addr, tbl[i].addr);
                chk($sformatf("vec%0d_pad_col", i), pad_col, tbl[i].pc);
            end
        end

        do_reset();
        run_frame(0, 0, -1, -1, 48, 99, 0, 2);
        run_frame(1, 0, -1, -1, 48, 99, 0, 4);
        run_frame(0, 1, -1, -1, 48, 99, 0, 6);
        run_frame(0, 0, 20, -1, 68, 125, 1, 3);

        run_frame(0, 0, -1, 85, 0, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        chk("async_rst_pad_row", pad_row, 0);
        chk("async_rst_win_shift", win_shift, 0);
        chk("async_rst_lb_wr_addr", lb_wr_addr, 0);
        chk("async_rst_lb_rot", lb_rot, 0);
        chk("async_rst_win_row", win_row, 0);
        chk("async_rst_pix_ready", pix_ready, 0);
        @(posedge clk); #1;
        rst_n = 1;
        fd_cnt = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("no_frame_done_after_abort", fd_cnt, 0);
        run_frame(0, 0, -1, -1, 48, 99, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
